// File: rtl/cc_matrix_serializer.sv
// MAX7219 serializer: sends the power-up init words, then one 8-row frame per
// refresh request, as 16-bit SPI words with a chip-select gap between words.
module cc_matrix_serializer #(
  parameter int         NUMBER_DATAWIDTH = 8,
  parameter int         CLKDIV           = 4,
  parameter logic [3:0] INTENSITY        = 4'h8
) (
  input  logic                        CC_MATRIX_SERIALIZER_CLOCK_50,
  input  logic                        CC_MATRIX_SERIALIZER_RESET_InLow,
  input  logic [NUMBER_DATAWIDTH-1:0] CC_MATRIX_SERIALIZER_regGAME_data7_InBus,
  input  logic [NUMBER_DATAWIDTH-1:0] CC_MATRIX_SERIALIZER_regGAME_data6_InBus,
  input  logic [NUMBER_DATAWIDTH-1:0] CC_MATRIX_SERIALIZER_regGAME_data5_InBus,
  input  logic [NUMBER_DATAWIDTH-1:0] CC_MATRIX_SERIALIZER_regGAME_data4_InBus,
  input  logic [NUMBER_DATAWIDTH-1:0] CC_MATRIX_SERIALIZER_regGAME_data3_InBus,
  input  logic [NUMBER_DATAWIDTH-1:0] CC_MATRIX_SERIALIZER_regGAME_data2_InBus,
  input  logic [NUMBER_DATAWIDTH-1:0] CC_MATRIX_SERIALIZER_regGAME_data1_InBus,
  input  logic [NUMBER_DATAWIDTH-1:0] CC_MATRIX_SERIALIZER_regGAME_data0_InBus,
  input  logic                        CC_MATRIX_SERIALIZER_update_InLow,
  output logic                        CC_MATRIX_SERIALIZER_spiDIN_Out,
  output logic                        CC_MATRIX_SERIALIZER_spiCLK_Out,
  output logic                        CC_MATRIX_SERIALIZER_spiCS_OutLow,
  output logic                        CC_MATRIX_SERIALIZER_busy_Out
);

  localparam int DW = $clog2(2 * CLKDIV);
  localparam logic [DW-1:0] HALF_LAST = DW'(CLKDIV - 1);
  localparam logic [DW-1:0] GAP_LAST  = DW'(2 * CLKDIV - 1);

  typedef enum logic [2:0] {INIT, IDLE, LATCH, SHIFT, GAP} state_t;

  logic clk;
  logic rst_n;
  logic update_n;
  assign clk      = CC_MATRIX_SERIALIZER_CLOCK_50;
  assign rst_n    = CC_MATRIX_SERIALIZER_RESET_InLow;
  assign update_n = CC_MATRIX_SERIALIZER_update_InLow;

  state_t                      state_q, state_d;
  logic [DW-1:0]               div_q, div_d;
  logic [3:0]                  bit_q, bit_d;
  logic [2:0]                  word_q, word_d;
  logic                        sclk_hi_q, sclk_hi_d;
  logic                        init_gap_q, init_gap_d;
  logic                        pending_q, pending_d;
  logic                        snap;
  logic [NUMBER_DATAWIDTH-1:0] rows_in [8];
  logic [NUMBER_DATAWIDTH-1:0] rows_q [8];

  logic        shifting;
  logic        gapping;
  logic        shift_end;
  logic        word_done;
  logic [15:0] cur_word;
  logic        din_d;

  always_comb begin
    rows_in[0] = CC_MATRIX_SERIALIZER_regGAME_data0_InBus;
    rows_in[1] = CC_MATRIX_SERIALIZER_regGAME_data1_InBus;
    rows_in[2] = CC_MATRIX_SERIALIZER_regGAME_data2_InBus;
    rows_in[3] = CC_MATRIX_SERIALIZER_regGAME_data3_InBus;
    rows_in[4] = CC_MATRIX_SERIALIZER_regGAME_data4_InBus;
    rows_in[5] = CC_MATRIX_SERIALIZER_regGAME_data5_InBus;
    rows_in[6] = CC_MATRIX_SERIALIZER_regGAME_data6_InBus;
    rows_in[7] = CC_MATRIX_SERIALIZER_regGAME_data7_InBus;
  end

  // INIT carries its own shift/gap phases, tracked by init_gap_q.
  always_comb begin
    shifting  = (state_q == SHIFT) || ((state_q == INIT) && !init_gap_q);
    gapping   = (state_q == GAP)   || ((state_q == INIT) &&  init_gap_q);
    shift_end = shifting && sclk_hi_q && (div_q == HALF_LAST) && (bit_q == 4'd15);
    word_done = gapping && (div_q == GAP_LAST);
  end

  always_comb begin
    cur_word = '0;
    if (state_q == INIT) begin
      unique case (word_q)
        3'd0:    cur_word = 16'h0C01;
        3'd1:    cur_word = 16'h0B07;
        3'd2:    cur_word = 16'h0900;
        3'd3:    cur_word = {8'h0A, 4'h0, INTENSITY};
        default: cur_word = 16'h0F00;
      endcase
    end else begin
      cur_word = {4'h0, {1'b0, word_q} + 4'd1, 8'(rows_q[word_q])};
    end
    din_d = shifting ? cur_word[4'd15 - bit_q] : 1'b0;
  end

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    word_d     = word_q;
    sclk_hi_d  = sclk_hi_q;
    init_gap_d = init_gap_q;
    pending_d  = pending_q;
    snap       = 1'b0;

    if (!update_n && (state_q != IDLE)) pending_d = 1'b1;

    if (shifting) begin
      div_d = div_q + 1'b1;
      if (div_q == HALF_LAST) begin
        div_d     = '0;
        sclk_hi_d = !sclk_hi_q;
        if (sclk_hi_q) bit_d = (bit_q == 4'd15) ? 4'd0 : bit_q + 4'd1;
      end
    end else if (gapping) begin
      div_d = (div_q == GAP_LAST) ? '0 : div_q + 1'b1;
    end

    unique case (state_q)
      INIT: begin
        if (shift_end) init_gap_d = 1'b1;
        if (word_done) begin
          init_gap_d = 1'b0;
          if (word_q == 3'd4) begin
            // The automatic first frame snapshots here instead of via LATCH,
            // so it follows the last init gap with no idle slot.
            word_d  = '0;
            snap    = 1'b1;
            state_d = SHIFT;
          end else begin
            word_d = word_q + 3'd1;
          end
        end
      end
      IDLE: if (!update_n) state_d = LATCH;
      LATCH: begin
        snap    = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: if (shift_end) state_d = GAP;
      GAP: begin
        if (word_done) begin
          if (word_q == 3'd7) begin
            word_d = '0;
            if (pending_q || !update_n) begin
              pending_d = 1'b0;
              state_d   = LATCH;
            end else begin
              state_d = IDLE;
            end
          end else begin
            word_d  = word_q + 3'd1;
            state_d = SHIFT;
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= INIT;
      div_q      <= '0;
      bit_q      <= '0;
      word_q     <= '0;
      sclk_hi_q  <= 1'b0;
      init_gap_q <= 1'b0;
      pending_q  <= 1'b0;
      for (int unsigned i = 0; i < 8; i++) rows_q[i] <= '0;
      CC_MATRIX_SERIALIZER_spiCS_OutLow <= 1'b1;
      CC_MATRIX_SERIALIZER_spiCLK_Out   <= 1'b0;
      CC_MATRIX_SERIALIZER_spiDIN_Out   <= 1'b0;
      CC_MATRIX_SERIALIZER_busy_Out     <= 1'b1;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      word_q     <= word_d;
      sclk_hi_q  <= sclk_hi_d;
      init_gap_q <= init_gap_d;
      pending_q  <= pending_d;
      if (snap) rows_q <= rows_in;
      CC_MATRIX_SERIALIZER_spiCS_OutLow <= !shifting;
      CC_MATRIX_SERIALIZER_spiCLK_Out   <= shifting && sclk_hi_q;
      CC_MATRIX_SERIALIZER_spiDIN_Out   <= din_d;
      CC_MATRIX_SERIALIZER_busy_Out     <= (state_q != IDLE);
    end
  end

endmodule

// File: tb/tb_cc_matrix_serializer.sv
// Directed bench for cc_matrix_serializer: decodes the SPI stream into words
// and compares them against hand-computed frames and timing.
module tb_cc_matrix_serializer;

  localparam int CLKDIV  = 4;
  localparam int WORD_LO = 32 * CLKDIV;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            upd_n = 1'b1;
  logic [7:0][7:0] rows = '0;
  logic            din, sclk, cs_n, busy;

  cc_matrix_serializer #(
    .NUMBER_DATAWIDTH(8),
    .CLKDIV(CLKDIV),
    .INTENSITY(4'h8)
  ) dut (
    .CC_MATRIX_SERIALIZER_CLOCK_50(clk),
    .CC_MATRIX_SERIALIZER_RESET_InLow(rst_n),
    .CC_MATRIX_SERIALIZER_regGAME_data7_InBus(rows[7]),
    .CC_MATRIX_SERIALIZER_regGAME_data6_InBus(rows[6]),
    .CC_MATRIX_SERIALIZER_regGAME_data5_InBus(rows[5]),
    .CC_MATRIX_SERIALIZER_regGAME_data4_InBus(rows[4]),
    .CC_MATRIX_SERIALIZER_regGAME_data3_InBus(rows[3]),
    .CC_MATRIX_SERIALIZER_regGAME_data2_InBus(rows[2]),
    .CC_MATRIX_SERIALIZER_regGAME_data1_InBus(rows[1]),
    .CC_MATRIX_SERIALIZER_regGAME_data0_InBus(rows[0]),
    .CC_MATRIX_SERIALIZER_update_InLow(upd_n),
    .CC_MATRIX_SERIALIZER_spiDIN_Out(din),
    .CC_MATRIX_SERIALIZER_spiCLK_Out(sclk),
    .CC_MATRIX_SERIALIZER_spiCS_OutLow(cs_n),
    .CC_MATRIX_SERIALIZER_busy_Out(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0][7:0]  rows;
    logic [7:0][15:0] words;
  } vec_t;

  typedef struct {
    logic [15:0] w;
    int unsigned lo;
    int unsigned hi;
  } rec_t;

  vec_t        vecs [3];
  rec_t        q [$];
  int unsigned nchecks = 0;
  int unsigned nerrors = 0;

  logic        prev_cs = 1'b1, prev_sclk = 1'b0, prev_din = 1'b0;
  logic [15:0] sh = '0;
  int unsigned nbits = 0, lo_len = 0, hi_len = 0, start_hi = 0, aborted = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Word decoder: DIN captured on each SCLK rise, checked stable while SCLK high.
  always @(negedge clk) begin
    if (!cs_n) begin
      if (prev_cs) begin
        nbits = 0; lo_len = 0; start_hi = hi_len; sh = '0;
      end
      lo_len++;
      if (sclk && !prev_sclk) begin
        sh = {sh[14:0], din};
        nbits++;
      end else if (sclk && prev_sclk) begin
        check("din_stable", {31'b0, din}, {31'b0, prev_din});
      end
    end else begin
      if (!prev_cs) begin
        if (nbits == 16) q.push_back('{sh, lo_len, start_hi});
        else aborted++;
        hi_len = 0;
      end
      hi_len++;
    end
    prev_cs = cs_n; prev_sclk = sclk; prev_din = din;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog");
  end

  task automatic wait_busy_low(input int unsigned limit, output int unsigned n);
    bit done = 0;
    n = 0;
    while (!done && n < limit) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (!busy) done = 1;
    end
    if (!done) begin
      nchecks++; nerrors++;
      $display("FAIL busy_timeout: busy still 1 after %0d cycles, want 0", n);
    end
  endtask

  task automatic pulse_update();
    @(negedge clk) upd_n = 1'b0;
    @(posedge clk);
    @(negedge clk) upd_n = 1'b1;
  endtask

  task automatic expect_word(input string name, input logic [15:0] w, output int unsigned hi);
    rec_t r;
    hi = 0;
    if (q.size() == 0) begin
      nchecks++; nerrors++;
      $display("FAIL %s: no word captured, want 0x%04h", name, w);
    end else begin
      r = q.pop_front();
      hi = r.hi;
      check(name, 32'(r.w), 32'(w));
      check({name, "_cs_low"}, r.lo, WORD_LO);
    end
  endtask

  task automatic expect_frame(input string name, input logic [7:0][15:0] words,
                              output int unsigned first_hi);
    int unsigned hi;
    first_hi = 0;
    for (int i = 0; i < 8; i++) begin
      expect_word($sformatf("%s_w%0d", name, i), words[i], hi);
      if (i == 0) first_hi = hi;
      else check($sformatf("%s_gap%0d", name, i), hi, 2 * CLKDIV);
    end
  endtask

  task automatic wait_words(input int unsigned count, input int unsigned limit);
    int unsigned n = 0;
    while (q.size() < count && n < limit) begin
      @(negedge clk); n++;
    end
    if (q.size() < count) begin
      nchecks++; nerrors++;
      $display("FAIL word_timeout: %0d words after %0d cycles, want %0d", q.size(), n, count);
    end
  endtask

  task automatic idle_quiet(input string name);
    bit seen = 0;
    repeat (300) begin
      @(negedge clk);
      if (busy || !cs_n) seen = 1;
    end
    check({name, "_no_activity"}, {31'b0, seen}, 32'd0);
    check({name, "_queue_empty"}, q.size(), 0);
  endtask

  task automatic release_and_init(input string name, input logic [7:0][15:0] frame);
    logic [15:0] iw [5];
    int unsigned n, hi;
    iw = '{16'h0C01, 16'h0B07, 16'h0900, 16'h0A08, 16'h0F00};
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    wait_busy_low(4000, n);
    check({name, "_busy_fall"}, n, 13 * 34 * CLKDIV);
    for (int i = 0; i < 5; i++) expect_word($sformatf("%s_init%0d", name, i), iw[i], hi);
    expect_frame({name, "_frame"}, frame, hi);
    check({name, "_frame_gap"}, hi, 2 * CLKDIV);
  endtask

  logic [7:0][15:0] zero_words, ff_words;
  int unsigned      n, hi, ab0;

  initial begin
    vecs[0].rows  = {8'h24, 8'h7E, 8'hFF, 8'hDB, 8'h7E, 8'h42, 8'hBD, 8'h81};
    vecs[0].words = {16'h0824, 16'h077E, 16'h06FF, 16'h05DB,
                     16'h047E, 16'h0342, 16'h02BD, 16'h0181};
    vecs[1].rows  = {8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    vecs[1].words = {16'h0801, 16'h0702, 16'h0604, 16'h0508,
                     16'h0410, 16'h0320, 16'h0240, 16'h0180};
    vecs[2].rows  = {8'h00, 8'hAA, 8'h55, 8'h00, 8'hFF, 8'hF0, 8'h0F, 8'hC3};
    vecs[2].words = {16'h0800, 16'h07AA, 16'h0655, 16'h0500,
                     16'h04FF, 16'h03F0, 16'h020F, 16'h01C3};
    zero_words = {16'h0800, 16'h0700, 16'h0600, 16'h0500,
                  16'h0400, 16'h0300, 16'h0200, 16'h0100};
    ff_words   = {16'h08FF, 16'h07FF, 16'h06FF, 16'h05FF,
                  16'h04FF, 16'h03FF, 16'h02FF, 16'h01FF};

    repeat (4) @(negedge clk);
    check("rst_cs", {31'b0, cs_n}, 32'd1);
    check("rst_sclk", {31'b0, sclk}, 32'd0);
    check("rst_din", {31'b0, din}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd1);

    release_and_init("boot", zero_words);

    for (int v = 0; v < 3; v++) begin
      @(negedge clk) rows = vecs[v].rows;
      pulse_update();
      @(negedge clk);
      check($sformatf("v%0d_latch_busy", v), {31'b0, busy}, 32'd1);
      check($sformatf("v%0d_latch_cs", v), {31'b0, cs_n}, 32'd1);
      @(negedge clk);
      check($sformatf("v%0d_first_cs", v), {31'b0, cs_n}, 32'd0);
      wait_busy_low(2000, n);
      check($sformatf("v%0d_frame_len", v), n, 8 * 34 * CLKDIV);
      expect_frame($sformatf("v%0d", v), vecs[v].words, hi);
      check($sformatf("v%0d_queue_empty", v), q.size(), 0);
    end

    // Rows change mid-frame: frame in flight keeps the snapshot.
    @(negedge clk) rows = vecs[0].rows;
    pulse_update();
    wait_words(2, 2000);
    rows = '1;
    wait_busy_low(2000, n);
    expect_frame("midchg_old", vecs[0].words, hi);
    idle_quiet("midchg");
    pulse_update();
    wait_busy_low(2000, n);
    expect_frame("midchg_new", ff_words, hi);

    // Request on the exact cycle the frame completes.
    @(negedge clk) rows = vecs[1].rows;
    pulse_update();
    repeat (8 * 34 * CLKDIV) @(posedge clk);
    @(negedge clk) upd_n = 1'b0;
    @(posedge clk);
    @(negedge clk) begin
      upd_n = 1'b1;
      rows  = vecs[2].rows;
    end
    wait_busy_low(4000, n);
    check("edge_req_len", n, 8 * 34 * CLKDIV + 2);
    expect_frame("edge_a", vecs[1].words, hi);
    expect_frame("edge_b", vecs[2].words, hi);
    check("edge_b_gap", hi, 2 * CLKDIV + 1);

    // Three requests during one frame coalesce into one extra frame.
    @(negedge clk) rows = vecs[2].rows;
    pulse_update();
    wait_words(1, 2000);
    for (int k = 0; k < 3; k++) begin
      repeat (20) @(negedge clk);
      pulse_update();
    end
    rows = vecs[0].rows;
    wait_busy_low(4000, n);
    expect_frame("coal_a", vecs[2].words, hi);
    expect_frame("coal_b", vecs[0].words, hi);
    check("coal_b_gap", hi, 2 * CLKDIV + 1);
    idle_quiet("coal");

    // Reset during bit 7 of the address-4 word.
    ab0 = aborted;
    @(negedge clk) rows = vecs[1].rows;
    pulse_update();
    n = 0;
    while (!(q.size() == 3 && nbits == 8 && !cs_n && !sclk) && n < 2000) begin
      @(negedge clk); #1; n++;
    end
    check("midword_reached", {31'b0, (q.size() == 3 && nbits == 8)}, 32'd1);
    rst_n = 1'b0;
    rows  = '0;
    @(negedge clk);
    check("midrst_cs", {31'b0, cs_n}, 32'd1);
    check("midrst_sclk", {31'b0, sclk}, 32'd0);
    check("midrst_din", {31'b0, din}, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd1);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) expect_word($sformatf("midrst_w%0d", i), vecs[1].words[i], hi);
    check("midrst_aborted", aborted - ab0, 1);
    release_and_init("rerun", zero_words);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule

// File: doc/cc_matrix_serializer.md
CC_MATRIX_SERIALIZER -- requirements
Module: cc_matrix_serializer

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset.
REQ-002 The block SHALL expose these parameters (name, default, meaning):
- NUMBER_DATAWIDTH, 8: row width.
- CLKDIV, 4: SPI half-period in clock cycles, minimum 2.
- INTENSITY, 4'h8: MAX7219 intensity code.
REQ-003 The block SHALL expose these ports (name, direction, width, meaning):
- CC_MATRIX_SERIALIZER_CLOCK_50, in, 1: system clock.
- CC_MATRIX_SERIALIZER_RESET_InLow, in, 1: synchronous reset, active low.
- CC_MATRIX_SERIALIZER_regGAME_data7_InBus .. data0_InBus, in, 8 each: eight row bytes from the screen comparator; data7 is the top row.
- CC_MATRIX_SERIALIZER_update_InLow, in, 1: refresh request, active low, sampled every cycle.
- CC_MATRIX_SERIALIZER_spiDIN_Out, out, 1: serial data to the MAX7219.
- CC_MATRIX_SERIALIZER_spiCLK_Out, out, 1: serial clock.
- CC_MATRIX_SERIALIZER_spiCS_OutLow, out, 1: chip select/LOAD, active low.
- CC_MATRIX_SERIALIZER_busy_Out, out, 1: high while the init sequence or a frame is in progress.

Function
REQ-004 Word format SHALL be 16 bits, MSB first: {4'h0, addr[3:0], data[7:0]}.
REQ-005 Word timing:
- Cycle 0: CS falls and DIN carries bit 15.
- SCLK SHALL start low, rise after CLKDIV cycles, fall after a further CLKDIV cycles.
- DIN SHALL change only on the cycle SCLK falls.
- After the 16th rising edge and its following falling edge, CS SHALL rise and stay high for 2*CLKDIV cycles (gap).
- Total word slot SHALL be 34*CLKDIV cycles.
REQ-006 The FSM states SHALL be INIT, IDLE, LATCH, SHIFT and GAP.
REQ-007 On reset release the block SHALL enter INIT and send five words in this order: 0x0C01, 0x0B07, 0x0900, {0x0A,4'h0,INTENSITY}, 0x0F00.
REQ-008 After the fifth word's gap, the block SHALL automatically run one display frame and then go to IDLE.
REQ-009 A display frame SHALL be eight words: addr 0x1 carries data0, through addr 0x8 carrying data7, sent in address order 0x1 to 0x8.
REQ-010 In LATCH (one cycle), all eight row inputs SHALL be snapshotted; input changes during SHIFT/GAP SHALL NOT affect the frame in flight.
REQ-011 In IDLE, update_InLow==0 SHALL move the FSM to LATCH on the next cycle.
REQ-012 A request arriving while busy SHALL set a single pending flag; multiple requests SHALL coalesce into one.
REQ-013 On frame completion with the pending flag set, the block SHALL clear the flag and go directly to LATCH, without an IDLE cycle.
REQ-014 A request on the same cycle a frame completes SHALL be treated as pending.
REQ-015 busy_Out SHALL be high in INIT, LATCH, SHIFT and GAP, and low only in IDLE.
REQ-016 Bit counter (0..15), word counter (0..7) and divider counter SHALL wrap to 0 at each word or frame boundary; no counter SHALL overflow into an adjacent state.
REQ-017 Outputs SHALL be registered, with no combinational path from inputs to the SPI pins.

Reset
REQ-018 While RESET_InLow==0 at a clock edge, the next-cycle outputs SHALL be: spiCS_OutLow=1, spiCLK_Out=0, spiDIN_Out=0, busy_Out=1.
REQ-019 While RESET_InLow==0 at a clock edge, the FSM SHALL be INIT word 0 and the pending flag and all counters SHALL be 0.
REQ-020 Reset asserted mid-word SHALL abort the word immediately (CS high on the next cycle) and restart the full init sequence after release.
REQ-021 Reset SHALL discard any snapshot and any pending request.

Verification
REQ-022 Reset, then release, CLKDIV=4 -> five init words 0x0C01, 0x0B07, 0x0900, 0x0A08, 0x0F00, then eight display words; busy_Out falls 13*136=1768 cycles after release.
REQ-023 Rows set to 0x24,0x7E,0xFF,0xDB,0x7E,0x42,0xBD,0x81 (data7..data0), one-cycle update pulse in IDLE -> words 0x0181, 0x02BD, 0x0342, 0x047E, 0x05DB, 0x06FF, 0x077E, 0x0824; CS low exactly 32*CLKDIV cycles per word.
REQ-024 Rows changed to all 0xFF mid-frame -> the current frame still carries the old bytes; the next frame carries 0xFF only if a request was made.
REQ-025 Three update pulses during one frame -> exactly one extra frame, starting with CS low 1 cycle after the prior gap ends.
REQ-026 Reset pulsed during bit 7 of word 0x04xx -> CS=1 and SCLK=0 on the next cycle; after release the first word is 0x0C01.
REQ-027 A scoreboard SHALL sample DIN on every SCLK rising edge and check that DIN is stable for the whole SCLK-high phase of every word.
